// File: rtl/regfile_tagged.sv
// Architectural register file with per-register rename status (busy + producer tag).
// CDB writeback is tag-matched with same-cycle read bypass; flush squashes all pending producers.
module regfile_tagged #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int REG_AW = 5,
  parameter int TAG_W  = 4,
  parameter int NRD    = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NRD-1:0]          re,
  input  logic [NRD*REG_AW-1:0]   raddr,
  output logic [NRD*XLEN-1:0]     rdata,
  output logic [NRD-1:0]          rbusy,
  output logic [NRD*TAG_W-1:0]    rtag,
  input  logic                    iss_valid,
  input  logic [REG_AW-1:0]       iss_rd,
  input  logic [TAG_W-1:0]        iss_tag,
  input  logic                    cdb_valid,
  input  logic [TAG_W-1:0]        cdb_tag,
  input  logic [XLEN-1:0]         cdb_data,
  input  logic                    flush,
  output logic [REG_AW:0]         busy_cnt
);

  localparam logic [REG_AW:0] NREGS_W = (REG_AW+1)'(NREGS);

  // Architectural state and its next-state image.
  logic [XLEN-1:0]  val_q [NREGS];
  logic [XLEN-1:0]  val_d [NREGS];
  logic [TAG_W-1:0] tag_q [NREGS];
  logic [TAG_W-1:0] tag_d [NREGS];
  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  // Per-register decode of the CDB and issue buses.
  logic [NREGS-1:0] cdb_match;
  logic [NREGS-1:0] iss_sel;
  logic [REG_AW:0]  cnt_d;

  // Per-port read results before packing onto the flat output buses.
  logic [XLEN-1:0]   port_data [NRD];
  logic [TAG_W-1:0]  port_tag  [NRD];
  logic [NRD-1:0]    port_busy;

  // Register 0 is hardwired: its match/select bits stay low so it can never turn busy.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    cdb_match = '0;
    iss_sel   = '0;
    for (int r = 1; r < NREGS; r++) begin
      cdb_match[r] = cdb_valid && busy_q[r] && (tag_q[r] == cdb_tag);
      iss_sel[r]   = iss_valid && (iss_rd == REG_AW'(r));
    end
  end

  // Next state: flush > issue > CDB for busy/tag; CDB alone decides val unless flushed.
  always_comb begin
    busy_d = busy_q;
    for (int r = 0; r < NREGS; r++) begin
      val_d[r] = val_q[r];
      tag_d[r] = tag_q[r];
    end
    for (int r = 1; r < NREGS; r++) begin
      if (flush) begin
        busy_d[r] = 1'b0;
      end else begin
        if (cdb_match[r]) begin
          val_d[r]  = cdb_data;
          busy_d[r] = 1'b0;
        end
        if (iss_sel[r]) begin
          busy_d[r] = 1'b1;
          tag_d[r]  = iss_tag;
        end
      end
    end
  end

  // Population count of the current busy bits; registered below, so busy_cnt trails busy by one edge.
  always_comb begin
    cnt_d = '0;
    for (int r = 1; r < NREGS; r++) begin
      cnt_d = cnt_d + (REG_AW+1)'(busy_q[r]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the value array is cleared on reset too, since software may read registers it never wrote.
      for (int r = 0; r < NREGS; r++) begin
        val_q[r] <= '0;
        tag_q[r] <= '0;
      end
      busy_q   <= '0;
      busy_cnt <= '0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
      for (int r = 0; r < NREGS; r++) begin
        val_q[r] <= val_d[r];
        tag_q[r] <= tag_d[r];
      end
      busy_q   <= busy_d;
      busy_cnt <= cnt_d;
    end
  end

  // Read ports: zero for reset/disabled/x0/out-of-range, else bypass a matching CDB, else stored state.
  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [REG_AW-1:0] addr;
    logic              in_range;

    assign addr     = raddr[p*REG_AW +: REG_AW];
    assign in_range = ({1'b0, addr} < NREGS_W);

    always_comb begin
      port_data[p] = '0;
      port_tag[p]  = '0;
      port_busy[p] = 1'b0;
      if (!rst && re[p] && (addr != '0) && in_range) begin
        if (cdb_match[addr] && !flush) begin
          port_data[p] = cdb_data;
        end else begin
          port_data[p] = val_q[addr];
          port_busy[p] = busy_q[addr];
          port_tag[p]  = busy_q[addr] ? tag_q[addr] : '0;
        end
      end
    end
  end

  always_comb begin
    rdata = '0;
    rtag  = '0;
    rbusy = port_busy;
    for (int p = 0; p < NRD; p++) begin
      rdata[p*XLEN +: XLEN]  = port_data[p];
      rtag[p*TAG_W +: TAG_W] = port_tag[p];
    end
  end

endmodule
